// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter shared by instruction fetch and MEM stage.
// Serialises 1/2/4-byte accesses into byte beats; MEM beats IF, no preemption.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   if_req/if_addr/if_flush       IF 4-byte fetch request, flush abort
//   if_data/if_done               fetched word, one-cycle completion pulse
//   mm_req/mm_we/mm_addr          MEM load/store request
//   mm_len/mm_wdata               size (00 b, 01 h, 1x w), store data
//   mm_rdata/mm_done              zero-extended load data, completion pulse
//   stallreq_if/stallreq_mem      requester still waiting
//   ram_din                       RAM read data, 1-cycle latency
//   ram_a/ram_dout/ram_wr         registered RAM address, data, strobe
module mem_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mm_req,
  input  logic              mm_we,
  input  logic [31:0]       mm_addr,
  input  logic [1:0]        mm_len,
  input  logic [31:0]       mm_wdata,
  output logic [31:0]       mm_rdata,
  output logic              mm_done,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr
);

  typedef enum logic [1:0] {
    IDLE,
    IF_RD,
    MM_RD,
    MM_WR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]        cnt;
  logic [2:0]        cnt_inc;
  logic [2:0]        cnt_dec;
  logic [2:0]        len;
  logic [2:0]        mm_n;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wbuf;
  logic [31:0]       rbuf;
  logic [4:0]        rd_sh;
  logic [4:0]        wr_sh;
  logic [31:0]       rd_full;
  logic [31:0]       wr_word;
  logic              any_done;
  logic              acc_mm;
  logic              acc_if;
  logic              rd_last;
  logic              wr_last;
  logic              unused_hi;

  assign unused_hi = ^{if_addr[31:ADDR_W], mm_addr[31:ADDR_W]};

  always_comb begin
    mm_n = 3'd4;
    unique case (1'b1)
      mm_len == 2'b00: mm_n = 3'd1;
      mm_len == 2'b01: mm_n = 3'd2;
      default:         mm_n = 3'd4;
    endcase
  end

  assign cnt_inc = cnt + 3'd1;
  assign cnt_dec = cnt - 3'd1;
  assign rd_sh   = {cnt_dec[1:0], 3'b000};
  assign wr_sh   = {cnt_inc[1:0], 3'b000};
  // The last byte lands on the same edge that raises done.
  assign rd_full = rbuf | ({24'b0, ram_din} << rd_sh);
  assign wr_word = wbuf >> wr_sh;

  // A done pulse still high means the dead cycle: nothing accepted.
  assign any_done = if_done | mm_done;
  assign acc_mm   = (state == IDLE) & ~any_done & mm_req;
  assign acc_if   = (state == IDLE) & ~any_done & ~mm_req
                  & if_req & ~if_flush;
  assign rd_last  = (cnt == len);
  assign wr_last  = (cnt_inc == len);

  assign stallreq_if  = if_req & ~if_done;
  assign stallreq_mem = mm_req & ~mm_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc_mm)      state_nx = mm_we ? MM_WR : MM_RD;
        else if (acc_if) state_nx = IF_RD;
      end
      IF_RD: begin
        if (if_flush || rd_last) state_nx = IDLE;
      end
      MM_RD: begin
        if (rd_last) state_nx = IDLE;
      end
      MM_WR: begin
        if (wr_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      len      <= '0;
      base     <= '0;
      wbuf     <= '0;
      rbuf     <= '0;
      ram_a    <= '0;
      ram_dout <= '0;
      ram_wr   <= 1'b0;
      if_data  <= '0;
      if_done  <= 1'b0;
      mm_rdata <= '0;
      mm_done  <= 1'b0;
    end else begin
      if_done <= 1'b0;
      mm_done <= 1'b0;
      ram_wr  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc_mm) begin
            base  <= mm_addr[ADDR_W-1:0];
            ram_a <= mm_addr[ADDR_W-1:0];
            len   <= mm_n;
            wbuf  <= mm_wdata;
            cnt   <= '0;
            rbuf  <= '0;
            if (mm_we) begin
              ram_dout <= mm_wdata[7:0];
              ram_wr   <= 1'b1;
            end
          end else if (acc_if) begin
            base  <= if_addr[ADDR_W-1:0];
            ram_a <= if_addr[ADDR_W-1:0];
            len   <= 3'd4;
            cnt   <= '0;
            rbuf  <= '0;
          end
        end
        IF_RD, MM_RD: begin
          if (!(state == IF_RD && if_flush)) begin
            cnt <= cnt_inc;
            if (cnt_inc < len)
              ram_a <= base + ADDR_W'(cnt_inc);
            if (cnt != 3'd0)
              rbuf <= rd_full;
            if (rd_last) begin
              if (state == IF_RD) begin
                if_data <= rd_full;
                if_done <= 1'b1;
              end else begin
                mm_rdata <= rd_full;
                mm_done  <= 1'b1;
              end
            end
          end
        end
        MM_WR: begin
          cnt <= cnt_inc;
          if (wr_last) begin
            mm_done <= 1'b1;
          end else begin
            ram_a    <= base + ADDR_W'(cnt_inc);
            ram_dout <= wr_word[7:0];
            ram_wr   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a byte-array RAM.
// Expected data comes from a shadow memory updated per transaction.
module tb_mem_arbiter;

  localparam int AW   = 17;
  localparam int MSZ  = 1 << AW;
  localparam int MASK = MSZ - 1;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_data;
  logic        if_done;
  logic        mm_req;
  logic        mm_we;
  logic [31:0] mm_addr;
  logic [1:0]  mm_len;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_done;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic [7:0]  ram_din;
  logic [AW-1:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_flush(if_flush), .if_data(if_data),
    .if_done(if_done), .mm_req(mm_req),
    .mm_we(mm_we), .mm_addr(mm_addr),
    .mm_len(mm_len), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata), .mm_done(mm_done),
    .stallreq_if(stallreq_if),
    .stallreq_mem(stallreq_mem),
    .ram_din(ram_din), .ram_a(ram_a),
    .ram_dout(ram_dout), .ram_wr(ram_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:MSZ-1];
  logic [7:0] ref_mem [0:MSZ-1];

  always @(posedge clk) begin
    if (ram_wr) mem[ram_a] <= ram_dout;
    ram_din <= mem[ram_a];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t         wrq [$];
  logic [31:0] ifq [$];
  logic [31:0] mmq [$];
  logic [31:0] last_if_exp;
  logic [31:0] last_mm_exp;
  int tests;
  int failed;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    tests++;
    failed++;
    $display("FAIL %s: got pulse expected none", nm);
  endtask

  function automatic int idx(input logic [31:0] a,
                             input int k);
    return int'((a + 32'(k)) & 32'(MASK));
  endfunction

  function automatic logic [31:0] ref_read(
      input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++)
      r[8*k +: 8] = ref_mem[idx(a, k)];
    return r;
  endfunction

  function automatic int nbytes(input logic [1:0] l);
    return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_mm(input bit we,
                          input logic [31:0] a,
                          input int n,
                          input logic [31:0] wd,
                          input int nb);
    wr_t e;
    if (we) begin
      for (int k = 0; k < nb; k++) begin
        ref_mem[idx(a, k)] = wd[8*k +: 8];
        e.a = AW'(idx(a, k));
        e.d = wd[8*k +: 8];
        wrq.push_back(e);
      end
    end else begin
      mmq.push_back(ref_read(a, n));
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows activity.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_wr) begin
        if (wrq.size() == 0) miss("ram_wr_beat");
        else begin
          wr_t e;
          e = wrq.pop_front();
          chk("wr_addr", 32'(ram_a), 32'(e.a));
          chk("wr_data", 32'(ram_dout), 32'(e.d));
        end
      end
      if (mm_done) begin
        chk("mm_done_wr_low", 32'(ram_wr), 32'd0);
        chk("if_data_hold", if_data, last_if_exp);
        if (mmq.size() == 0) begin
          last_mm_exp = mm_rdata;
          if (mm_we === 1'b0) miss("mm_done_read");
        end else begin
          logic [31:0] x;
          x = mmq.pop_front();
          chk("mm_rdata", mm_rdata, x);
          last_mm_exp = x;
        end
      end
      if (if_done) begin
        chk("mm_rdata_hold", mm_rdata, last_mm_exp);
        if (ifq.size() == 0) miss("if_done");
        else begin
          logic [31:0] x;
          x = ifq.pop_front();
          chk("if_data", if_data, x);
          last_if_exp = x;
        end
      end
    end
  end

  task automatic wait_done(input bit is_if,
                           input int exp_cyc,
                           input string nm);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(is_if ? if_done : mm_done) && c < 40);
    chk(nm, 32'(c), 32'(exp_cyc));
  endtask

  task automatic run_mm(input bit we,
                        input logic [31:0] a,
                        input logic [1:0] l,
                        input logic [31:0] wd);
    int n;
    n = nbytes(l);
    model_mm(we, a, n, wd, n);
    @(negedge clk);
    mm_req = 1'b1;
    mm_we = we;
    mm_addr = a;
    mm_len = l;
    mm_wdata = wd;
    #1 chk("mm_stall", 32'(stallreq_mem), 32'd1);
    @(posedge clk);
    #1;
    mm_addr = $urandom;
    mm_len = 2'($urandom);
    mm_wdata = $urandom;
    wait_done(1'b0, we ? n + 1 : n + 2, "mm_latency");
    chk("mm_stall_done", 32'(stallreq_mem), 32'd0);
    mm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_if(input logic [31:0] a);
    ifq.push_back(ref_read(a, 4));
    @(negedge clk);
    if_req = 1'b1;
    if_addr = a;
    #1 chk("if_stall", 32'(stallreq_if), 32'd1);
    @(posedge clk);
    #1 if_addr = $urandom;
    wait_done(1'b1, 6, "if_latency");
    chk("if_stall_done", 32'(stallreq_if), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_both(input logic [31:0] ia,
                          input bit we,
                          input logic [31:0] a,
                          input logic [1:0] l,
                          input logic [31:0] wd);
    int n;
    n = nbytes(l);
    model_mm(we, a, n, wd, n);
    ifq.push_back(ref_read(ia, 4));
    @(negedge clk);
    if_req = 1'b1;
    if_addr = ia;
    mm_req = 1'b1;
    mm_we = we;
    mm_addr = a;
    mm_len = l;
    mm_wdata = wd;
    @(posedge clk);
    #1 mm_wdata = $urandom;
    wait_done(1'b0, we ? n + 1 : n + 2, "both_mm_lat");
    mm_req = 1'b0;
    chk("both_if_stall", 32'(stallreq_if), 32'd1);
    wait_done(1'b1, 7, "both_if_lat");
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ram_a"}, 32'(ram_a), 32'd0);
    chk({nm, "_ram_dout"}, 32'(ram_dout), 32'd0);
    chk({nm, "_ram_wr"}, 32'(ram_wr), 32'd0);
    chk({nm, "_if_data"}, if_data, 32'd0);
    chk({nm, "_if_done"}, 32'(if_done), 32'd0);
    chk({nm, "_mm_rdata"}, mm_rdata, 32'd0);
    chk({nm, "_mm_done"}, 32'(mm_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    tests = 0;
    failed = 0;
    last_if_exp = '0;
    last_mm_exp = '0;
    rst = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    if_flush = 1'b0;
    mm_req = 1'b0;
    mm_we = 1'b0;
    mm_addr = '0;
    mm_len = '0;
    mm_wdata = '0;
    for (int i = 0; i < MSZ; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[32'h1000] = 8'h13;
    mem[32'h1001] = 8'h00;
    mem[32'h1002] = 8'h00;
    mem[32'h1003] = 8'h00;
    mem[32'h30] = 8'h80;
    mem[32'h1FFFF] = 8'hA5;
    mem[0] = 8'h5A;
    for (int i = 0; i < 4; i++)
      ref_mem[32'h1000 + i] = mem[32'h1000 + i];
    ref_mem[32'h30] = 8'h80;
    ref_mem[32'h1FFFF] = 8'hA5;
    ref_mem[0] = 8'h5A;

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b1;
    @(negedge clk);

    run_if(32'h1000);
    chk("if_word_0x1000", if_data, 32'h0000_0013);
    run_mm(1'b1, 32'h20, 2'b10, 32'hDEAD_BEEF);
    run_both(32'h1000, 1'b0, 32'h30, 2'b00, 32'h0);
    chk("mem_first_byte", mm_rdata, 32'h0000_0080);

    // Flush in the cycle after E2 aborts the fetch.
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h3000;
    repeat (3) @(negedge clk);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0;
    if_req = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_done) seen++;
    end
    chk("flush_no_done", 32'(seen), 32'd0);
    chk("flush_if_data", if_data, last_if_exp);
    run_if(32'h2000);

    // Reset lands after two store bytes reached the RAM.
    model_mm(1'b1, 32'h40, 4, 32'h1122_3344, 2);
    @(negedge clk);
    mm_req = 1'b1;
    mm_we = 1'b1;
    mm_addr = 32'h40;
    mm_len = 2'b10;
    mm_wdata = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    mm_req = 1'b0;
    #1 chk_reset_outs("midrst");
    last_if_exp = '0;
    last_mm_exp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_mm(1'b0, 32'h40, 2'b10, 32'h0);

    run_mm(1'b0, 32'h1FFFF, 2'b01, 32'h0);
    chk("wrap_half", mm_rdata, 32'h0000_5AA5);

    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      logic [31:0] b;
      int kind;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0)
        a = {a[31:AW], 15'h7FFF, 2'($urandom)};
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_if(b);
        1: run_mm(1'b0, a, 2'($urandom), b);
        2: run_mm(1'b1, a, 2'($urandom), b);
        default: run_both(b, 1'($urandom), a,
                          2'($urandom), $urandom);
      endcase
    end

    repeat (5) @(negedge clk);
    chk("ifq_empty", 32'(ifq.size()), 32'd0);
    chk("mmq_empty", 32'(mmq.size()), 32'd0);
    chk("wrq_empty", 32'(wrq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule
